// File: rtl/audio_codec_seq_pkg.sv
// Shared types and the codec register table for the audio codec configuration sequencer.
// The table holds one 16-bit word per register write: {reg_addr[6:0], reg_data[8:0]}.
package audio_codec_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE_WAIT,
        ST_LOAD,
        ST_FRAME,
        ST_GAP,
        ST_DONE,
        ST_ERR
    } seq_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_BIT,
        TX_STOP
    } tx_state_t;

    localparam int unsigned NUM_REGS     = 10;
    localparam int unsigned GAP_QUARTERS = 8;
    localparam logic [3:0]  LAST_IDX     = 4'(NUM_REGS - 1);

    function automatic logic [15:0] reg_entry(input logic [3:0] i);
        logic [15:0] e;
        e = '0;
        case (i)
            4'd0: e = {7'h0F, 9'h000};   // codec reset
            4'd1: e = {7'h04, 9'h012};   // DAC select
            4'd2: e = {7'h05, 9'h000};
            4'd3: e = {7'h06, 9'h067};
            4'd4: e = {7'h07, 9'h002};   // I2S, 16-bit
            4'd5: e = {7'h08, 9'h000};
            4'd6: e = {7'h09, 9'h001};   // active
            4'd7: e = {7'h02, 9'h079};   // left headphone volume
            4'd8: e = {7'h03, 9'h079};   // right headphone volume
            4'd9: e = {7'h00, 9'h017};   // left line-in volume
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/audio_codec_seq_if.sv
// Frame handshake between the table sequencer (master) and the I2C frame engine (slave).
interface audio_codec_seq_if;
    logic        go;
    logic [23:0] word;
    logic        ack_ok;
    logic        nack;
    logic        idle;

    modport master (output go, output word, input ack_ok, input nack, input idle);
    modport slave  (input go, input word, output ack_ok, output nack, output idle);
endinterface

// File: rtl/audio_codec_seq_frame_tx.sv
// I2C write-frame engine: START, three bytes with ACK check, STOP; 4 quarters per bit.
// Reports exactly one ack_ok or nack pulse per accepted go.
module i2c_frame_tx
    import audio_codec_pkg::*;
#(
    parameter int unsigned QDIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    audio_codec_seq_if.slave   fr,
    input  logic               sda_in,
    output logic               scl,
    output logic               sda_low
);

    localparam int unsigned     DIV_W    = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(QDIV - 1);

    tx_state_t        state, state_n;
    logic [DIV_W-1:0] div_cnt, div_n;
    logic [1:0]       q, q_n;
    logic [3:0]       bit_cnt, bit_n;
    logic [1:0]       byte_cnt, byte_n;
    logic [23:0]      shreg, shreg_n;
    logic             nack_seen, nack_seen_n;
    logic             scl_n, sda_low_n;
    logic             ack_q, nack_q, ack_n, nack_n;
    logic             tick;

    assign fr.idle   = (state == TX_IDLE);
    assign fr.ack_ok = ack_q;
    assign fr.nack   = nack_q;

    always_comb begin
        state_n     = state;
        div_n       = div_cnt;
        q_n         = q;
        bit_n       = bit_cnt;
        byte_n      = byte_cnt;
        shreg_n     = shreg;
        nack_seen_n = nack_seen;
        ack_n       = 1'b0;
        nack_n      = 1'b0;
        tick        = (div_cnt == DIV_LAST);

        if (state == TX_IDLE) begin
            div_n = '0;
            q_n   = '0;
            if (fr.go) begin
                state_n     = TX_START;
                shreg_n     = fr.word;
                bit_n       = '0;
                byte_n      = '0;
                nack_seen_n = 1'b0;
            end
        end else begin
            div_n = tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                q_n = q + 2'd1;
                case (state)
                    TX_START: if (q == 2'd3) state_n = TX_BIT;
                    TX_BIT: begin
                        if (q == 2'd2 && bit_cnt == 4'd8) nack_seen_n = sda_in;
                        if (q == 2'd3) begin
                            if (bit_cnt == 4'd8) begin
                                bit_n = '0;
                                // A NACK skips the remaining bytes and goes straight to STOP
                                if (nack_seen || byte_cnt == 2'd2) state_n = TX_STOP;
                                else byte_n = byte_cnt + 2'd1;
                            end else begin
                                bit_n   = bit_cnt + 4'd1;
                                shreg_n = {shreg[22:0], 1'b0};
                            end
                        end
                    end
                    TX_STOP: if (q == 2'd3) begin
                        state_n = TX_IDLE;
                        ack_n   = ~nack_seen;
                        nack_n  = nack_seen;
                    end
                    default: state_n = TX_IDLE;
                endcase
            end
        end

        // Line levels for the current quarter; registered so SCL/SDA never glitch
        scl_n     = 1'b1;
        sda_low_n = 1'b0;
        case (state)
            TX_START: begin
                scl_n     = (q != 2'd3);
                sda_low_n = (q != 2'd0);
            end
            TX_BIT: begin
                scl_n     = (q == 2'd1) || (q == 2'd2);
                sda_low_n = (bit_cnt != 4'd8) && !shreg[23];
            end
            TX_STOP: begin
                scl_n     = (q != 2'd0);
                sda_low_n = (q < 2'd2);
            end
            default: begin
                scl_n     = 1'b1;
                sda_low_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            div_cnt   <= '0;
            q         <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            shreg     <= '0;
            nack_seen <= 1'b0;
            scl       <= 1'b1;
            sda_low   <= 1'b0;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state     <= state_n;
            div_cnt   <= div_n;
            q         <= q_n;
            bit_cnt   <= bit_n;
            byte_cnt  <= byte_n;
            shreg     <= shreg_n;
            nack_seen <= nack_seen_n;
            scl       <= scl_n;
            sda_low   <= sda_low_n;
            ack_q     <= ack_n;
            nack_q    <= nack_n;
        end
    end

endmodule

// File: rtl/audio_codec_seq.sv
// Audio codec boot sequencer: walks the register table over I2C, retrying NACKed
// entries up to MAX_RETRY times, and reports done/err.
module audio_codec_seq
    import audio_codec_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned I2C_HZ    = 20000,
    parameter logic [7:0]  DEV_ADDR  = 8'h34,
    parameter int unsigned BOOT_CYC  = 1024,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] idx,
    output logic       i2c_sclk,
    inout  wire        i2c_sdat
);

    localparam int unsigned QDIV_RAW = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned QDIV     = (QDIV_RAW == 0) ? 1 : QDIV_RAW;
    localparam int unsigned GAP_CLKS = GAP_QUARTERS * QDIV;
    localparam int unsigned BOOT_W   = $clog2(BOOT_CYC + 1);
    localparam int unsigned GAP_W    = $clog2(GAP_CLKS + 1);
    localparam int unsigned RETRY_W  = $clog2(MAX_RETRY + 2);

    localparam logic [BOOT_W-1:0]  BOOT_LAST = BOOT_W'((BOOT_CYC > 0) ? BOOT_CYC - 1 : 0);
    localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(GAP_CLKS - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    seq_state_t         state, state_n;
    logic [BOOT_W-1:0]  boot_cnt, boot_n;
    logic [GAP_W-1:0]   gap_cnt, gap_n;
    logic [3:0]         idx_q, idx_n;
    logic [RETRY_W-1:0] retry, retry_n;
    logic               go;
    logic               sda_low;
    logic               sda_in;

    audio_codec_seq_if fr ();

    assign fr.go   = go;
    assign fr.word = {DEV_ADDR, reg_entry(idx_q)};

    i2c_frame_tx #(.QDIV(QDIV)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .fr      (fr),
        .sda_in  (sda_in),
        .scl     (i2c_sclk),
        .sda_low (sda_low)
    );

    assign i2c_sdat = sda_low ? 1'b0 : 1'bz;
    assign sda_in   = i2c_sdat;

    always_comb begin
        state_n = state;
        boot_n  = boot_cnt;
        gap_n   = gap_cnt;
        idx_n   = idx_q;
        retry_n = retry;
        go      = 1'b0;

        case (state)
            ST_BOOT: begin
                if (boot_cnt == BOOT_LAST) state_n = ST_IDLE_WAIT;
                else boot_n = boot_cnt + 1'b1;
            end
            ST_IDLE_WAIT: begin
                state_n = ST_LOAD;
                idx_n   = '0;
                retry_n = '0;
            end
            ST_LOAD: begin
                if (fr.idle) begin
                    go      = 1'b1;
                    state_n = ST_FRAME;
                end
            end
            ST_FRAME: begin
                if (fr.nack) begin
                    if (retry == RETRY_MAX) state_n = ST_ERR;
                    else begin
                        retry_n = retry + 1'b1;
                        state_n = ST_LOAD;
                    end
                end else if (fr.ack_ok) begin
                    retry_n = '0;
                    gap_n   = '0;
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (idx_q == LAST_IDX) state_n = ST_DONE;
                    else begin
                        idx_n   = idx_q + 4'd1;
                        state_n = ST_LOAD;
                    end
                end else begin
                    gap_n = gap_cnt + 1'b1;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_n = ST_LOAD;
                    idx_n   = '0;
                    retry_n = '0;
                end
            end
            default: state_n = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            boot_cnt <= '0;
            gap_cnt  <= '0;
            idx_q    <= '0;
            retry    <= '0;
        end else begin
            state    <= state_n;
            boot_cnt <= boot_n;
            gap_cnt  <= gap_n;
            idx_q    <= idx_n;
            retry    <= retry_n;
        end
    end

    assign busy = (state == ST_LOAD) || (state == ST_FRAME) || (state == ST_GAP);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERR);
    assign idx  = idx_q;

endmodule
